// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and default constants for the unified memory port arbiter.
//   owner_e          : which requester owns the read data returning this cycle
//   DEF_ADDR_W       : default address width
//   DEF_DATA_W       : default data width
//   DEF_STARVE_LIMIT : default number of denied fetch cycles before fetch wins
//   STARVE_CNT_W     : width of the starvation counter (limit must fit in it)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_F = 2'd1,
    RD_D = 2'd2
  } owner_e;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W     = 4;

endpackage

// File: rtl/mem_arb_grant.sv
// mem_arb_grant
// Purely combinational grant selector. Data has priority on contention
// unless fetch has been denied for STARVE_LIMIT consecutive cycles.
// Ports:
//   inhibit    in  forces both grants low (used while reset is high)
//   f_req      in  fetch request
//   d_req      in  data request
//   starve_cnt in  consecutive denied fetch cycles (registered)
//   f_gnt      out fetch granted
//   d_gnt      out data granted
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                    inhibit,
  input  logic                    f_req,
  input  logic                    d_req,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output logic                    f_gnt,
  output logic                    d_gnt
);

  logic starved;

  // The counter saturates at the limit, so >= behaves as == here but stays
  // safe if the counter is ever observed above the limit.
  assign starved = (starve_cnt >= STARVE_CNT_W'(STARVE_LIMIT));

  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!inhibit) begin
      if (f_req && (!d_req || starved)) begin
        f_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous memory between instruction fetch and
// load/store. At most one access is granted per cycle; read data comes back
// one cycle later tagged to the requester that issued it.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   f_req/f_addr/f_gnt             fetch request channel
//   f_rvalid/f_rdata               fetch read response
//   d_req/d_we/d_addr/d_wdata/d_gnt data request channel
//   d_rvalid/d_rdata               load read response
//   m_en/m_we/m_addr/m_wdata       memory command port
//   m_rdata                        memory read data (one cycle after read)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  owner_e                  state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;

  // Grant selection; reset forces both grants (and hence the port) idle.
  mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .inhibit   (reset),
    .f_req     (f_req),
    .d_req     (d_req),
    .starve_cnt(starve_q),
    .f_gnt     (f_gnt),
    .d_gnt     (d_gnt)
  );

  // Memory command port, zeroed when nothing is granted. Fetch never writes,
  // so write data is only forwarded for a data grant.
  always_comb begin
    m_en    = f_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt) begin
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (f_gnt) begin
      m_addr  = f_addr;
    end
  end

  // Starvation counter: counts consecutive cycles fetch asked and lost.
  always_comb begin
    starve_d = '0;
    if (f_req && !f_gnt) begin
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 1'b1;
    end
  end

  // Response owner state machine: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next-state: remember who owns the read that was just issued. Stores
  // return nothing, so they go to IDLE like an empty cycle.
  always_comb begin
    state_d = IDLE;
    if (f_gnt) begin
      state_d = RD_F;
    end else if (d_gnt && !d_we) begin
      state_d = RD_D;
    end
  end

  // Outputs: read data is shared, the valid flags carry ownership.
  always_comb begin
    f_rvalid = (state_q == RD_F);
    d_rvalid = (state_q == RD_D);
    f_rdata  = m_rdata;
    d_rdata  = m_rdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_gnt, f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Synchronous single-port memory driven by the DUT's port.
  logic [DW-1:0] sim_mem [256];
  always @(posedge clk) begin
    if (m_en && m_we)  sim_mem[m_addr[9:2]] <= m_wdata;
    if (m_en && !m_we) m_rdata <= sim_mem[m_addr[9:2]];
  end

  // Reference memory contents, updated by the model in grant order.
  logic [DW-1:0] ref_mem [256];

  typedef struct {
    int            cyc;
    bit            fg, dg, en, we, chk_wdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } port_exp_t;

  typedef struct {
    int            cyc;
    bit            is_f;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rd_exp_t;

  port_exp_t port_q[$];
  rd_exp_t   rd_q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_chk = 0;
  int  n_fail = 0;
  bit  started = 0;
  int  ref_starve = 0;

  // Pending requests held by the requesters until granted.
  bit            fp = 0, dp = 0, dp_we = 0;
  logic [AW-1:0] fp_addr = '0, dp_addr = '0;
  logic [DW-1:0] dp_wdata = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [7:0] w;
    w = 8'($urandom_range(0, 255));
    return {22'd0, w, 2'b00};
  endfunction

  // One cycle of stimulus: present the pending requests, predict the
  // arbiter's behaviour from the rules, then advance to the next cycle.
  task automatic cycle_step();
    port_exp_t pe;
    rd_exp_t   re;
    bit        fg, dg;
    f_req   = fp;
    f_addr  = fp ? fp_addr : rand_addr();
    d_req   = dp;
    d_we    = dp ? dp_we : 1'($urandom_range(0, 1));
    d_addr  = dp ? dp_addr : rand_addr();
    d_wdata = dp ? dp_wdata : $urandom;
    if (reset) begin
      fg = 0;
      dg = 0;
    end else begin
      fg = f_req && (!d_req || ref_starve >= LIM);
      dg = d_req && !fg;
    end
    pe.cyc       = cyc;
    pe.fg        = fg;
    pe.dg        = dg;
    pe.en        = fg || dg;
    pe.we        = dg && d_we;
    pe.addr      = fg ? f_addr : (dg ? d_addr : '0);
    pe.wdata     = dg ? d_wdata : '0;
    pe.chk_wdata = !fg;
    port_q.push_back(pe);
    if (reset) begin
      ref_starve = 0;
    end else begin
      if (fg) begin
        re.cyc = cyc + 1; re.is_f = 1; re.addr = f_addr; re.data = ref_mem[f_addr[9:2]];
        rd_q.push_back(re);
        fp = 0;
      end
      if (dg) begin
        if (d_we) begin
          ref_mem[d_addr[9:2]] = d_wdata;
        end else begin
          re.cyc = cyc + 1; re.is_f = 0; re.addr = d_addr; re.data = ref_mem[d_addr[9:2]];
          rd_q.push_back(re);
        end
        dp = 0;
      end
      if (f_req && !fg) ref_starve = (ref_starve + 1 > LIM) ? LIM : ref_starve + 1;
      else              ref_starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    rd_q.delete();       // responses in flight are dropped by reset
    repeat (n) cycle_step();
    reset = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((fp || dp) && guard < 20) begin
      cycle_step();
      guard++;
    end
    if (fp || dp) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles", guard);
    end
    cycle_step();
    cycle_step();
  endtask

  // Monitor: compare the port every cycle and pop returned reads.
  always @(negedge clk) begin
    if (started) begin
      if (port_q.size() == 0 || port_q[0].cyc != cyc) begin
        chk("port_sync", 64'(port_q.size()), 64'hFFFF);
      end else begin
        port_exp_t pe;
        pe = port_q.pop_front();
        chk("f_gnt", 64'(f_gnt), 64'(pe.fg));
        chk("d_gnt", 64'(d_gnt), 64'(pe.dg));
        chk("m_en", 64'(m_en), 64'(pe.en));
        chk("m_we", 64'(m_we), 64'(pe.we));
        chk("m_addr", 64'(m_addr), 64'(pe.addr));
        if (pe.chk_wdata) chk("m_wdata", 64'(m_wdata), 64'(pe.wdata));
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        rd_exp_t re;
        re = rd_q.pop_front();
        chk("f_rvalid", 64'(f_rvalid), 64'(re.is_f));
        chk("d_rvalid", 64'(d_rvalid), 64'(!re.is_f));
        if (re.is_f) chk("f_rdata", 64'(f_rdata), 64'(re.data));
        else         chk("d_rdata", 64'(d_rdata), 64'(re.data));
        $display("rd %s addr=%h data=%h cycle=%0d", re.is_f ? "F" : "D",
                 re.addr, re.is_f ? f_rdata : d_rdata, cyc);
      end else begin
        chk("f_rvalid_idle", 64'(f_rvalid), 64'd0);
        chk("d_rvalid_idle", 64'(d_rvalid), 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      sim_mem[i] = $urandom;
      ref_mem[i] = sim_mem[i];
    end
    sim_mem[8'h40] = 32'h00500093; ref_mem[8'h40] = 32'h00500093;  // 0x100
    sim_mem[8'h80] = 32'h12345678; ref_mem[8'h80] = 32'h12345678;  // 0x200

    @(posedge clk);
    #1;
    started = 1;
    do_reset(2);

    // Fetch only
    fp = 1; fp_addr = 32'h100;
    drain();

    // Contention: data wins first, fetch follows
    fp = 1; fp_addr = 32'h104;
    dp = 1; dp_we = 0; dp_addr = 32'h200;
    drain();

    // Starvation: both held high with continuous loads
    for (int i = 0; i < 12; i++) begin
      if (!fp) begin fp = 1; fp_addr = rand_addr(); end
      if (!dp) begin dp = 1; dp_we = 0; dp_addr = rand_addr(); end
      cycle_step();
    end
    fp = 0; dp = 0;
    cycle_step();

    // Store then load back
    dp = 1; dp_we = 1; dp_addr = 32'h300; dp_wdata = 32'hDEADBEEF;
    drain();
    dp = 1; dp_we = 0; dp_addr = 32'h300;
    drain();

    // Reset in the cycle after a load grant
    dp = 1; dp_we = 0; dp_addr = 32'h200;
    cycle_step();
    do_reset(2);
    fp = 1; fp_addr = 32'h100;
    dp = 1; dp_we = 0; dp_addr = 32'h200;
    drain();

    // Randomized traffic with occasional drops and resets
    for (int i = 0; i < 2500; i++) begin
      if (fp && $urandom_range(0, 19) == 0) fp = 0;
      if (dp && $urandom_range(0, 19) == 0) dp = 0;
      if (!fp && $urandom_range(0, 3) != 0) begin fp = 1; fp_addr = rand_addr(); end
      if (!dp && $urandom_range(0, 2) != 0) begin
        dp = 1; dp_we = ($urandom_range(0, 2) == 0); dp_addr = rand_addr(); dp_wdata = $urandom;
      end
      if ($urandom_range(0, 299) == 0) do_reset(1 + $urandom_range(0, 1));
      else                             cycle_step();
    end
    fp = 0; dp = 0;
    cycle_step();
    cycle_step();

    chk("port_q_empty", 64'(port_q.size()), 64'd0);
    chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
    started = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one unified single-port synchronous memory between the core's instruction-fetch requester and its load/store requester. It replaces the separate instruction and data memories so the core can run from one shared memory. Each cycle it grants at most one request and drives the memory port. It returns read data, tagged to the owning requester, one cycle later. A starvation counter guarantees fetch progress under continuous data traffic.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win (legal range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- f_req  in  1  fetch request; held with f_addr stable until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- m_en  out  1  memory access enable
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid the cycle after a read with m_en=1, m_we=0

## Operation
- Grant selection is combinational from the current requests and registered state. Grants are mutually exclusive.
  - Only one request asserted: that requester is granted.
  - Both asserted, starve_cnt < STARVE_LIMIT: data is granted.
  - Both asserted, starve_cnt == STARVE_LIMIT: fetch is granted.
- Memory port outputs:
  - m_en = f_gnt | d_gnt.
  - m_addr and m_wdata are muxed from the granted requester.
  - m_we = d_gnt & d_we.
  - With no grant, m_we = 0 and m_addr/m_wdata hold 0.
- starve_cnt is a 4-bit register:
  - increments when f_req=1 and f_gnt=0;
  - clears to 0 on f_gnt, or when f_req=0;
  - saturates at STARVE_LIMIT.
- Response tracking uses a registered state machine with states IDLE, RD_F and RD_D.
  - Next state is RD_F after a fetch grant, RD_D after a data load grant, and IDLE otherwise (no grant, or a store).
  - f_rvalid = (state==RD_F); d_rvalid = (state==RD_D).
  - f_rdata = d_rdata = m_rdata. Read data is meaningful only while the matching rvalid is set.
- Back-to-back accesses are fully pipelined. A new grant is allowed in the same cycle a previous read's data returns, giving 1 access per cycle of throughput.
- A store produces no rvalid on either requester.

## Timing
- Grant to memory port: 0 cycles (combinational).
- Grant to rvalid: exactly 1 cycle, for reads only.
- Reset values: state=IDLE, starve_cnt=0, f_rvalid=0, d_rvalid=0.
- Grant and memory-port outputs are forced to 0 while reset is high.
- Reset asserted mid-operation:
  - Any pending response is dropped, with rvalid cleared asynchronously.
  - No memory write is issued while reset is high.
- A request deasserted without receiving a grant is legal. No state is retained for it.
- Simultaneous data grant while starve_cnt == STARVE_LIMIT-1: starve_cnt reaches the limit, and fetch is granted the next cycle if still requesting.

## Structure
- Shared package mem_arb_pkg holds:
  - owner state typedef (IDLE, RD_F, RD_D);
  - default ADDR_W, DATA_W and STARVE_LIMIT constants.
- One sub-module is natural: mem_arb_grant, a purely combinational priority and starvation grant selector. The top level holds the state register, starve_cnt and the memory-port muxes.

## Test plan
- Fetch only: f_req=1, f_addr=0x100, memory[0x100]=0x00500093. Required: f_gnt=1 and m_addr=0x100 in the same cycle; f_rvalid=1 and f_rdata=0x00500093 the next cycle; d_rvalid stays 0.
- Contention: f_req=1 at 0x104 and d_req=1 load at 0x200 (holding 0x12345678) in the same cycle. Required: d_gnt=1, f_gnt=0; next cycle d_rvalid=1 with d_rdata=0x12345678 and f_gnt=1; the cycle after that f_rvalid=1.
- Starvation: STARVE_LIMIT=4, f_req held high, d_req held high with loads. Required: d_gnt in cycles 0–3; f_gnt in cycle 4; starve_cnt=0 in cycle 5 and d_gnt resumes.
- Store then load: d_we=1, d_addr=0x300, d_wdata=0xDEADBEEF. Required: m_we=1 for one cycle and no rvalid. A following load of 0x300 gives d_rvalid=1 and d_rdata=0xDEADBEEF.
- Reset mid-read: assert reset asynchronously in the cycle after a load grant. Required: d_rvalid drops to 0 immediately and m_en=0; after release, state=IDLE and starve_cnt=0.
